dqs_rx_calib: RTL and testbench

//  Receive-side DQS calibration engine: sweeps the input delay (IDELAY) tap for a DQS/DQ lane.
//  At each tap it checks 4-bit deserialized samples against an expected pattern.
//  It finds the longest contiguous passing tap window and programs the window centre.

---
 rtl/dqs_rx_calib.sv | 254 +++++++++++++++++++++++++
 tb/tb_dqs_rx_calib.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dqs_rx_calib.sv
// -----------------------------------------------------------------------------
// dqs_rx_calib
//
// Receive-side DQS calibration engine. Sweeps the IDELAY tap of one DQS/DQ
// lane from 0 to 31. At each tap it waits for the delay line to settle, then
// checks NSAMP consecutive 4-bit deserialized words against PATTERN. The
// longest contiguous run of passing taps is tracked, and at the end of the
// sweep the centre of that run is programmed into the delay line. If the best
// run is shorter than MIN_WIN, or the sweep was aborted because dly_ready
// fell, the previous centre is re-programmed and fail is raised.
//
// Parameters
//   PATTERN  expected sample word while DQS toggles (D1 = bit 0)
//   SETTLE   cycles waited after each tap load before sampling (>= 1)
//   NSAMP    consecutive words that must all match for a tap to pass (1..255)
//   MIN_WIN  minimum passing window length in taps for success (1..32)
//
// Ports
//   clk          lane clock (clk_div domain of the SERDES)
//   rst_n        asynchronous active-low reset
//   start        one-cycle sweep request, ignored while busy
//   dly_ready    IDELAYCTRL ready
//   dqs_samples  deserialized DQS sample word, valid every clk
//   dly_data     tap value presented to idelay_pipe
//   dly_ld       one-cycle load strobe for dly_data
//   dly_set      one-cycle set strobe, the cycle after dly_ld
//   busy         sweep in progress
//   done         one-cycle pulse at sweep end
//   fail         sticky result flag, valid from done until next start
//   center       selected tap; last good value held on fail
//   win_len      length of the best window (0..32)
//   pass_map     (DQS_CAL_HIST_EN only) per-tap pass result of the last sweep
//
// Optional feature macro: DQS_CAL_HIST_EN adds the pass_map output.
// -----------------------------------------------------------------------------
module dqs_rx_calib #(
   parameter logic [3:0] PATTERN = 4'b0101,
   parameter int         SETTLE  = 8,
   parameter int         NSAMP   = 16,
   parameter int         MIN_WIN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        dly_ready,
   input  logic [3:0]  dqs_samples,
   output logic [4:0]  dly_data,
   output logic        dly_ld,
   output logic        dly_set,
   output logic        busy,
   output logic        done,
   output logic        fail,
   output logic [4:0]  center,
   output logic [5:0]  win_len
`ifdef DQS_CAL_HIST_EN
   ,
   output logic [31:0] pass_map
`endif
);

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] NSAMP_LAST  = CNT_W'(NSAMP - 1);
   localparam logic [5:0]       MIN_WIN_L   = 6'(MIN_WIN);
   localparam logic [4:0]       LAST_TAP    = 5'd31;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_LOAD,
      S_SET,
      S_SETTLE,
      S_SAMPLE,
      S_EVAL,
      S_FINISH,
      S_FIN_LD,
      S_FIN_SET,
      S_DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [4:0]        tap_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              pass_acc_q;
   logic [5:0]        cur_len_q;
   logic [4:0]        cur_start_q;
   logic [5:0]        best_len_q;
   logic [4:0]        best_start_q;
   logic              abort_q;
   logic [4:0]        dly_data_q;

   logic [5:0]        cur_len_n;
   logic [4:0]        cur_start_n;
   logic              sweep_active;

   // Window centre; best_start + len/2 never exceeds 31 because the window
   // itself lies inside taps 0..31, so the 6-bit sum fits in 5 bits.
   function automatic logic [4:0] win_center(input logic [4:0] w_start,
                                             input logic [5:0] w_len);
      logic [5:0] sum;
      sum = {1'b0, w_start} + (w_len >> 1);
      return sum[4:0];
   endfunction

   // States in which the delay line is being swept; losing dly_ready here
   // invalidates the measurement.
   assign sweep_active = (state_q == S_LOAD)   || (state_q == S_SET)    ||
                         (state_q == S_SETTLE) || (state_q == S_SAMPLE) ||
                         (state_q == S_EVAL);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start) state_d = S_WAIT_RDY;
         S_WAIT_RDY: if (dly_ready) state_d = S_LOAD;
         S_LOAD:     state_d = S_SET;
         S_SET:      state_d = S_SETTLE;
         S_SETTLE:   if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
         S_SAMPLE:   if (cnt_q == NSAMP_LAST) state_d = S_EVAL;
         S_EVAL:     state_d = (tap_q == LAST_TAP) ? S_FINISH : S_LOAD;
         S_FINISH:   state_d = S_FIN_LD;
         S_FIN_LD:   state_d = S_FIN_SET;
         S_FIN_SET:  state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      if (sweep_active && !dly_ready) begin
         state_d = S_FINISH;
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      dly_ld   = (state_q == S_LOAD) || (state_q == S_FIN_LD);
      dly_set  = (state_q == S_SET)  || (state_q == S_FIN_SET);
      done     = (state_q == S_DONE);
      busy     = (state_q != S_IDLE) && (state_q != S_DONE);
      dly_data = dly_data_q;
      if (state_q == S_LOAD) begin
         dly_data = tap_q;
      end else if (state_q == S_FIN_LD) begin
         // center was already resolved in FINISH (new or held value)
         dly_data = center;
      end
   end

   // Run tracker update for the tap being evaluated.
   always_comb begin
      cur_len_n   = cur_len_q;
      cur_start_n = cur_start_q;
      if (pass_acc_q) begin
         cur_len_n = cur_len_q + 6'd1;
         if (cur_len_q == 6'd0) begin
            cur_start_n = tap_q;
         end
      end else begin
         cur_len_n = 6'd0;
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q        <= '0;
         cnt_q        <= '0;
         pass_acc_q   <= 1'b0;
         cur_len_q    <= '0;
         cur_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         abort_q      <= 1'b0;
         dly_data_q   <= '0;
         fail         <= 1'b0;
         center       <= '0;
         win_len      <= '0;
`ifdef DQS_CAL_HIST_EN
         pass_map     <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  fail       <= 1'b0;
                  best_len_q <= '0;
                  cur_len_q  <= '0;
                  tap_q      <= '0;
                  abort_q    <= 1'b0;
`ifdef DQS_CAL_HIST_EN
                  pass_map   <= '0;
`endif
               end
            end
            S_LOAD: begin
               dly_data_q <= tap_q;
               cnt_q      <= '0;
            end
            S_SETTLE: begin
               // Counter wraps to 0 so SAMPLE starts counting from zero.
               cnt_q      <= (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
               pass_acc_q <= 1'b1;
            end
            S_SAMPLE: begin
               cnt_q      <= (cnt_q == NSAMP_LAST) ? '0 : cnt_q + 1'b1;
               pass_acc_q <= pass_acc_q & (dqs_samples == PATTERN);
            end
            S_EVAL: begin
               cur_len_q   <= cur_len_n;
               cur_start_q <= cur_start_n;
               // Strict compare keeps the earliest window on ties.
               if (cur_len_n > best_len_q) begin
                  best_len_q   <= cur_len_n;
                  best_start_q <= cur_start_n;
               end
`ifdef DQS_CAL_HIST_EN
               pass_map[tap_q] <= pass_acc_q;
`endif
               // No wrap: a run reaching tap 31 ends here with the sweep.
               if (tap_q != LAST_TAP) begin
                  tap_q <= tap_q + 5'd1;
               end
            end
            S_FINISH: begin
               win_len <= best_len_q;
               if (!abort_q && (best_len_q >= MIN_WIN_L)) begin
                  center <= win_center(best_start_q, best_len_q);
                  fail   <= 1'b0;
               end else begin
                  fail   <= 1'b1;
               end
            end
            S_FIN_LD: begin
               dly_data_q <= center;
            end
            default: ;
         endcase
         if (sweep_active && !dly_ready) begin
            abort_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dqs_rx_calib.sv
// -----------------------------------------------------------------------------
// tb_dqs_rx_calib
//
// Directed bench for dqs_rx_calib with default parameters. A small lane model
// follows dly_ld/dly_data and returns PATTERN at taps whose bit is set in
// lane_mask, and 4'b0110 elsewhere. Expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_dqs_rx_calib;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        dly_ready;
   logic [3:0]  dqs_samples;
   logic [4:0]  dly_data;
   logic        dly_ld;
   logic        dly_set;
   logic        busy;
   logic        done;
   logic        fail;
   logic [4:0]  center;
   logic [5:0]  win_len;
`ifdef DQS_CAL_HIST_EN
   logic [31:0] pass_map;
`endif

   dqs_rx_calib dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dly_ready   (dly_ready),
      .dqs_samples (dqs_samples),
      .dly_data    (dly_data),
      .dly_ld      (dly_ld),
      .dly_set     (dly_set),
      .busy        (busy),
      .done        (done),
      .fail        (fail),
      .center      (center),
      .win_len     (win_len)
`ifdef DQS_CAL_HIST_EN
      ,
      .pass_map    (pass_map)
`endif
   );

   always #5 clk = ~clk;

   // Lane model: the delay line takes the tap presented with dly_ld.
   logic [31:0] lane_mask;
   logic [4:0]  lane_tap;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      lane_tap <= 5'd0;
      else if (dly_ld) lane_tap <= dly_data;
   end

   assign dqs_samples = lane_mask[lane_tap] ? 4'b0101 : 4'b0110;

   int done_cnt = 0;
   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Wait (at negedges) for done; optionally pulse start at cycle poke_a/poke_b.
   task automatic wait_done(input string tag, input int budget,
                            input int poke_a, input int poke_b);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         start = (i == poke_a) || (i == poke_b);
         if (done) begin
            seen = 1'b1;
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            break;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic run_sweep(input string tag, input logic [31:0] mask,
                            input int poke_a, input int poke_b);
      lane_mask = mask;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(tag, 2000, poke_a, poke_b);
   endtask

   initial begin
      int   d0;
      logic ld_seen;
      logic hit;

      rst_n     = 1'b0;
      start     = 1'b0;
      dly_ready = 1'b1;
      lane_mask = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_done",     32'(done),     32'd0);
      chk("rst_fail",     32'(fail),     32'd0);
      chk("rst_center",   32'(center),   32'd0);
      chk("rst_win_len",  32'(win_len),  32'd0);
      chk("rst_dly_ld",   32'(dly_ld),   32'd0);
      chk("rst_dly_set",  32'(dly_set),  32'd0);
      chk("rst_dly_data", 32'(dly_data), 32'd0);

      // Too-short window (8..10) right after reset: fail, restore tap 0
      run_sweep("t4", 32'h0000_0700, -1, -1);
      chk("t4_fail",    32'(fail),    32'd1);
      chk("t4_win_len", 32'(win_len), 32'd3);
      chk("t4_center",  32'(center),  32'd0);
      @(negedge clk);
      chk("t4_dly_data", 32'(dly_data), 32'd0);
      chk("t4_lane_tap", 32'(lane_tap), 32'd0);

      // Single window 10..19
      run_sweep("t1", 32'h000F_FC00, -1, -1);
      chk("t1_fail",    32'(fail),    32'd0);
      chk("t1_win_len", 32'(win_len), 32'd10);
      chk("t1_center",  32'(center),  32'd15);
      @(negedge clk);
      chk("t1_lane_tap", 32'(lane_tap), 32'd15);

      // Two equal windows 3..6 and 20..23: earliest wins
      run_sweep("t2", 32'h00F0_0078, -1, -1);
      chk("t2_fail",    32'(fail),    32'd0);
      chk("t2_win_len", 32'(win_len), 32'd4);
      chk("t2_center",  32'(center),  32'd5);

      // Window 25..31 plus taps 0..1: no wrap-around join
      run_sweep("t3", 32'hFE00_0003, -1, -1);
      chk("t3_fail",    32'(fail),    32'd0);
      chk("t3_win_len", 32'(win_len), 32'd7);
      chk("t3_center",  32'(center),  32'd28);

      // dly_ready gating and mid-sweep abort
      lane_mask = 32'h000F_FC00;
      dly_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ld_seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (dly_ld) ld_seen = 1'b1;
      end
      chk("t5_no_ld_while_not_ready", 32'(ld_seen), 32'd0);
      chk("t5_busy_waiting",          32'(busy),    32'd1);
      chk("t5_fail_cleared",          32'(fail),    32'd0);
      dly_ready = 1'b1;
      @(negedge clk);
      chk("t5_first_ld",  32'(dly_ld),   32'd1);
      chk("t5_first_tap", 32'(dly_data), 32'd0);
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (dly_ld && dly_data == 5'd12) begin
            hit = 1'b1;
            break;
         end
      end
      chk("t5_reached_tap12", 32'(hit), 32'd1);
      dly_ready = 1'b0;
      wait_done("t5", 20, -1, -1);
      chk("t5_fail",   32'(fail),   32'd1);
      chk("t5_center", 32'(center), 32'd28);
      @(negedge clk);
      chk("t5_dly_data", 32'(dly_data), 32'd28);
      chk("t5_lane_tap", 32'(lane_tap), 32'd28);
      dly_ready = 1'b1;

      // Scenario 1 again with start pulses mid-sweep: exactly one done
      d0 = done_cnt;
      run_sweep("t6", 32'h000F_FC00, 100, 500);
      repeat (5) @(negedge clk);
      chk("t6_done_count", 32'(done_cnt - d0), 32'd1);
      chk("t6_center",     32'(center),        32'd15);
      chk("t6_win_len",    32'(win_len),       32'd10);
      chk("t6_idle",       32'(busy),          32'd0);
`ifdef DQS_CAL_HIST_EN
      chk("t6_pass_map",   pass_map,           32'h000F_FC00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
